// File: rtl/uart_rx_fifo.sv
// Receive-side circular FIFO between the UART receiver and the register block.
// Show-ahead read port, level status, level interrupt and sticky overrun flag.
module uart_rx_fifo #(
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned THRESHOLD = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     rx_data_valid,
  input  logic [7:0]               rx_data,
  input  logic                     rx_error,
  input  logic                     rd_en,
  input  logic                     flush,
  input  logic                     clear_overrun,
  output logic [7:0]               rd_data,
  output logic                     rd_frame_err,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     level_irq,
  output logic                     overrun
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned EW = 9;

  logic [EW-1:0] mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [CW-1:0] count_nxt;
  logic [EW-1:0] head;
  logic          push_ok;
  logic          pop_ok;
  logic          ovr_set;

  // Status decodes of the registered count
  assign empty     = (count == '0);
  assign full      = (count == CW'(DEPTH));
  assign level_irq = (count >= CW'(THRESHOLD));

  // Flush wins over both sides; a pop frees room for a push when full
  assign pop_ok  = rd_en & ~empty & ~flush;
  assign push_ok = rx_data_valid & ~flush & (~full | pop_ok);
  assign ovr_set = rx_data_valid & full & ~pop_ok & ~flush;

  // Show-ahead head entry, forced to zero while empty
  assign head         = mem[rptr];
  assign rd_data      = empty ? 8'h00 : head[7:0];
  assign rd_frame_err = empty ? 1'b0  : head[8];

  always_comb begin
    count_nxt = count;
    if (push_ok && !pop_ok) begin
      count_nxt = count + CW'(1);
    end else if (!push_ok && pop_ok) begin
      count_nxt = count - CW'(1);
    end
  end

  // Storage array carries no reset
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wptr] <= {rx_error, rx_data};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr    <= '0;
      rptr    <= '0;
      count   <= '0;
      overrun <= 1'b0;
    end else begin
      if (flush) begin
        wptr  <= '0;
        rptr  <= '0;
        count <= '0;
      end else begin
        if (push_ok) wptr <= wptr + AW'(1);
        if (pop_ok)  rptr <= rptr + AW'(1);
        count <= count_nxt;
      end
      // A drop in the same cycle as a clear leaves the flag set
      if (ovr_set) begin
        overrun <= 1'b1;
      end else if (clear_overrun) begin
        overrun <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: queue-based reference model checked every cycle,
// directed scenarios with literal pins, then randomized traffic.
module tb_uart_rx_fifo;

  localparam int unsigned DEPTH     = 16;
  localparam int unsigned THRESHOLD = 8;
  localparam int unsigned CW        = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          rx_data_valid = 1'b0;
  logic [7:0]    rx_data = 8'h00;
  logic          rx_error = 1'b0;
  logic          rd_en = 1'b0;
  logic          flush = 1'b0;
  logic          clear_overrun = 1'b0;
  logic [7:0]    rd_data;
  logic          rd_frame_err;
  logic          empty;
  logic          full;
  logic [CW-1:0] count;
  logic          level_irq;
  logic          overrun;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  logic [8:0] q[$];
  bit         m_ovr = 1'b0;

  uart_rx_fifo #(.DEPTH(DEPTH), .THRESHOLD(THRESHOLD)) dut (
    .clk(clk), .rst_n(rst_n), .rx_data_valid(rx_data_valid), .rx_data(rx_data),
    .rx_error(rx_error), .rd_en(rd_en), .flush(flush), .clear_overrun(clear_overrun),
    .rd_data(rd_data), .rd_frame_err(rd_frame_err), .empty(empty), .full(full),
    .count(count), .level_irq(level_irq), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a bounded queue plus a sticky flag
  always @(posedge clk) begin
    bit popped, pushed, set_ev;
    if (!rst_n) begin
      q.delete();
      m_ovr = 1'b0;
    end else begin
      set_ev = rx_data_valid && (q.size() == DEPTH) && !rd_en && !flush;
      if (flush) begin
        q.delete();
      end else begin
        popped = rd_en && (q.size() > 0);
        pushed = rx_data_valid && ((q.size() < DEPTH) || popped);
        if (popped) void'(q.pop_front());
        if (pushed) q.push_back({rx_error, rx_data});
      end
      if (set_ev) m_ovr = 1'b1;
      else if (clear_overrun) m_ovr = 1'b0;
    end
  end

  // Per-cycle compare against the model
  always @(negedge clk) begin
    if (chk_en) begin
      chk("count", int'(count), q.size());
      chk("empty", int'(empty), int'(q.size() == 0));
      chk("full", int'(full), int'(q.size() == DEPTH));
      chk("level_irq", int'(level_irq), int'(q.size() >= THRESHOLD));
      chk("overrun", int'(overrun), int'(m_ovr));
      chk("rd_data", int'(rd_data), (q.size() > 0) ? int'(q[0][7:0]) : 0);
      chk("rd_frame_err", int'(rd_frame_err), (q.size() > 0) ? int'(q[0][8]) : 0);
    end
  end

  task automatic cyc(input logic v, input logic [7:0] d, input logic e,
                     input logic r, input logic f, input logic c);
    rx_data_valid = v; rx_data = d; rx_error = e;
    rd_en = r; flush = f; clear_overrun = c;
    @(negedge clk);
  endtask

  task automatic idle();
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic push(input logic [7:0] d, input logic e);
    cyc(1'b1, d, e, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic pop();
    cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    idle();
    chk_en = 1'b1;
    chk("rst_empty", int'(empty), 1);
    chk("rst_count", int'(count), 0);
    chk("rst_rd_data", int'(rd_data), 0);
    rst_n = 1'b1;

    // Single byte round trip
    push(8'hA5, 1'b0);
    chk("a5_rd_data", int'(rd_data), 8'hA5);
    chk("a5_count", int'(count), 1);
    chk("a5_empty", int'(empty), 0);
    pop();
    chk("a5_pop_empty", int'(empty), 1);
    chk("a5_pop_rd_data", int'(rd_data), 0);
    pop();
    chk("pop_empty_noeffect", int'(count), 0);

    // Two fills with wrap, frame error on 0x07
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < 16; i++) begin
        push(8'(i), 1'(i == 7));
        chk("fill_irq", int'(level_irq), int'(i + 1 >= 8));
      end
      chk("fill_full", int'(full), 1);
      chk("fill_count", int'(count), 16);
      if (pass == 0) begin
        for (int i = 0; i < 16; i++) begin
          chk("drain_data", int'(rd_data), i);
          chk("drain_ferr", int'(rd_frame_err), int'(i == 7));
          pop();
        end
        chk("drain_empty", int'(empty), 1);
      end
    end

    // Overrun on full, clear, then set-beats-clear
    push(8'hEE, 1'b0);
    chk("ovr_set", int'(overrun), 1);
    chk("ovr_count", int'(count), 16);
    chk("ovr_head", int'(rd_data), 0);
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("ovr_clear", int'(overrun), 0);
    cyc(1'b1, 8'hEE, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("ovr_set_wins", int'(overrun), 1);
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);

    // Full push+pop, then drain to find 0x55 last
    cyc(1'b1, 8'h55, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("fullpp_count", int'(count), 16);
    chk("fullpp_ovr", int'(overrun), 0);
    for (int i = 0; i < 15; i++) begin
      chk("fullpp_drain", int'(rd_data), i + 1);
      pop();
    end
    chk("fullpp_last", int'(rd_data), 8'h55);
    pop();
    cyc(1'b1, 8'h77, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("emptypp_count", int'(count), 1);
    chk("emptypp_data", int'(rd_data), 8'h77);
    pop();

    // Set overrun, then flush with a push on 5 entries
    for (int i = 0; i < 17; i++) push(8'(8'h80 + i), 1'b0);
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) push(8'(8'h90 + i), 1'b1);
    cyc(1'b1, 8'h99, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("flush_count", int'(count), 0);
    chk("flush_empty", int'(empty), 1);
    chk("flush_ovr_kept", int'(overrun), 1);
    push(8'h3C, 1'b0);
    chk("flush_next", int'(rd_data), 8'h3C);

    // Reset mid-operation with 10 entries
    for (int i = 0; i < 9; i++) push(8'(8'hC0 + i), 1'b0);
    chk("pre_rst_count", int'(count), 10);
    rst_n = 1'b0;
    cyc(1'b1, 8'hDD, 1'b1, 1'b1, 1'b0, 1'b0);
    rst_n = 1'b1;
    chk("mid_rst_count", int'(count), 0);
    chk("mid_rst_empty", int'(empty), 1);
    chk("mid_rst_ovr", int'(overrun), 0);
    chk("mid_rst_data", int'(rd_data), 0);
    chk("mid_rst_irq", int'(level_irq), 0);

    // Randomized traffic with alternating fill/drain bias
    for (int blk = 0; blk < 40; blk++) begin
      int push_pct = (blk % 2 == 0) ? 80 : 25;
      int pop_pct  = (blk % 2 == 0) ? 25 : 80;
      for (int i = 0; i < 60; i++) begin
        logic v, r, f, c;
        v = 1'($urandom_range(99) < push_pct);
        r = 1'($urandom_range(99) < pop_pct);
        f = 1'($urandom_range(63) == 0);
        c = 1'($urandom_range(15) == 0);
        rst_n = ($urandom_range(499) == 0) ? 1'b0 : 1'b1;
        cyc(v, 8'($urandom), 1'($urandom), r, f, c);
      end
    end
    rst_n = 1'b1;
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Receive-side buffer placed directly downstream of the UART receiver. It captures each byte the receiver reports through its one-cycle valid strobe, together with that byte's frame-error flag, and holds them in a circular FIFO. The CPU-facing UART register block drains the FIFO through a show-ahead read port. The block also reports level status, a level interrupt and a sticky overrun flag.

Parameters:
DEPTH, 16, number of entries; must be a power of 2 and at least 2
THRESHOLD, 8, level_irq asserts when count >= THRESHOLD; range 1..DEPTH

Ports:
clk  input  1  system clock
rst_n  input  1  reset, synchronous, active-low
rx_data_valid  input  1  one-cycle push strobe from the receiver
rx_data  input  8  received byte; sampled when rx_data_valid=1
rx_error  input  1  frame error for the byte presented with rx_data_valid
rd_en  input  1  pop strobe from the register block
flush  input  1  discard all entries
clear_overrun  input  1  clears the sticky overrun flag
rd_data  output  8  head byte (show-ahead)
rd_frame_err  output  1  frame-error flag of the head entry
empty  output  1  count == 0
full  output  1  count == DEPTH
count  output  $clog2(DEPTH)+1  number of stored entries
level_irq  output  1  count >= THRESHOLD
overrun  output  1  sticky flag: a byte was dropped because the FIFO was full

Behaviour:
- Clock and reset: one clock, clk. rst_n is synchronous and active-low and is sampled only on the rising edge of clk.
- Reset values:
  - write pointer, read pointer, count and overrun all 0
  - empty=1, full=0, level_irq=0
  - rd_data=0, rd_frame_err=0
  - storage array is not reset
- Storage: DEPTH entries, each 9 bits {rx_error, rx_data}.
  - Pointers are $clog2(DEPTH) bits and wrap from DEPTH-1 to 0 naturally.
  - count is tracked separately, so full and empty are never ambiguous.
- Push:
  - push_ok = rx_data_valid & ~flush & (~full | pop_ok).
  - On push_ok, the entry is written at wptr and wptr increments on that edge.
- Pop:
  - pop_ok = rd_en & ~empty & ~flush.
  - rptr increments on that edge.
  - rd_en while empty is ignored and has no side effects.
- Read port (show-ahead):
  - rd_data and rd_frame_err are driven combinationally from the entry at rptr.
  - When empty=1 both are forced to 0.
  - A byte pushed at edge N is visible on rd_data after edge N (zero added latency).
- Count update per edge: count + push_ok - pop_ok.
- Full with simultaneous push and pop: both occur, count stays at DEPTH and overrun is not set.
- Empty with simultaneous push and pop: the pop is ignored and the push occurs, so count becomes 1.
- Overrun:
  - Set on the edge where rx_data_valid=1, full=1, pop_ok=0 and flush=0. The byte is dropped and the FIFO contents are unchanged.
  - Cleared by clear_overrun.
  - If a set event and clear_overrun occur in the same cycle, set wins.
  - flush does not clear overrun.
- Flush:
  - On the edge where flush=1: wptr, rptr and count all go to 0.
  - flush has priority over push and pop in the same cycle; a push in that cycle is discarded and does not set overrun.
- level_irq and the status outputs (empty, full, count) are combinational decodes of the registered count. Each updates in the cycle after the causing edge.
- Reset mid-operation: all state returns to reset values on the next clk edge where rst_n=0, regardless of push, pop or flush activity.
- Input protocol: the receiver guarantees rx_data_valid is high for at most one cycle per byte. The FIFO nonetheless handles back-to-back pushes, one per cycle.

Test Plan:
- Reset, then push 0xA5 with rx_error=0 → empty falls after 1 edge, rd_data=0xA5, rd_frame_err=0, count=1. Pop → empty=1, rd_data=0.
- Push 0x00..0x0F (16 bytes, DEPTH=16), with byte 0x07 flagged rx_error=1 → full=1, count=16, level_irq=1 from count 8 onward. Pop all → data returned in order, rd_frame_err=1 only for 0x07, wrap-around exercised on the second fill.
- FIFO full, push 0xEE with no pop → overrun=1, count=16, 0xEE never appears on readout. clear_overrun → overrun=0. Overrun event and clear_overrun in the same cycle → overrun=1.
- FIFO full, push 0x55 and pop in the same cycle → count stays 16, overrun=0, 0x55 is read last. FIFO empty, push and pop in the same cycle → count=1, rd_data = pushed byte.
- FIFO holding 5 entries, flush asserted together with a push → count=0, empty=1, overrun unchanged. Next push of 0x3C → rd_data=0x3C.
- Fill 10 entries, then drive rst_n=0 for one edge while pushing and popping → count=0, empty=1, overrun=0, rd_data=0, level_irq=0.
